chunked_add_sub: RTL and testbench

//  Multi-cycle, parametrised adder/subtractor for the datapath ALU: S = A + (sub ? ~B : B) + cin,

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_chunk.sv | 26 ++
 rtl/chunked_add_sub.sv | 148 ++++++++++++++
 tb/tb_chunked_add_sub.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple-carry adder slice; also exposes the carry into the MSB.
module addsub_chunk #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_into_msb
);

  always_comb begin
    logic [W:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout       = c[W];
    c_into_msb = c[W-1];
  end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry registered between chunks,
// NZCV flags, valid/ready on both sides with one operation in flight.
module chunked_add_sub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [3:0]       flags
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_add_sub: WIDTH must be a multiple of CHUNK");
  end

  addsub_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bi_q, bi_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  nzcv_t            flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic             cout_ch, cmsb_ch;

  addsub_chunk #(.W(CHUNK)) u_chunk (
    .a          (a_ch),
    .b          (b_ch),
    .cin        (carry_q),
    .s          (sum_ch),
    .cout       (cout_ch),
    .c_into_msb (cmsb_ch)
  );

  // Operand chunk selected by the counter; out-of-range counts select zero.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = bi_q[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    bi_d        = bi_q;
    carry_d     = carry_q;
    s_d         = s_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          bi_d    = b ^ {WIDTH{sub}};
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) s_d[k*CHUNK +: CHUNK] = sum_ch;
        end
        carry_d = cout_ch;
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          // Overflow is the carry into the MSB differing from the carry out of it.
          flags_d.n   = s_d[WIDTH-1];
          flags_d.z   = (s_d == '0);
          flags_d.c   = cout_ch;
          flags_d.v   = cout_ch ^ cmsb_ch;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      bi_q        <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      bi_q        <= bi_d;
      carry_q     <= carry_d;
      s_q         <= s_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: a CHUNK=16 and a CHUNK=64 instance, directed vectors,
// stall/reset sequences and a randomized scoreboard against plain 65-bit arithmetic.
module tb_chunked_add_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [63:0] a_i      [2];
  logic [63:0] b_i      [2];
  logic        sub_i    [2];
  logic        cin_i    [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [63:0] s_o      [2];
  logic [3:0]  f_o      [2];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  chunked_add_sub #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[0]), .b(b_i[0]), .sub(sub_i[0]), .cin(cin_i[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .s(s_o[0]), .flags(f_o[0])
  );

  chunked_add_sub #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i[1]), .b(b_i[1]), .sub(sub_i[1]), .cin(cin_i[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .s(s_o[1]), .flags(f_o[1])
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic [63:0] exp_s;
    logic [3:0]  exp_f;
  } vec_t;

  typedef struct {
    logic [63:0] s;
    logic [3:0]  f;
  } res_t;

  // Reference: widen to 65 bits and read flags off the exact result.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic cin);
    res_t        r;
    logic [63:0] bi;
    logic [64:0] full;
    bi   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bi} + {64'd0, cin};
    r.s  = full[63:0];
    r.f  = {full[63], (full[63:0] == 64'd0), full[64],
            (a[63] == bi[63]) && (full[63] != a[63])};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Present operands when in_ready is seen; returns after the accepting edge.
  task automatic issue(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin);
    int n = 0;
    while (!in_ready[d] && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready[d]) begin
      total++;
      $display("FAIL in_ready_timeout dut%0d: in_ready stayed 0", d);
    end
    a_i[d] = a; b_i[d] = b; sub_i[d] = sub; cin_i[d] = cin; in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk($sformatf("out_valid_drop dut%0d", d), 64'(out_valid[d]), 64'd0);
  endtask

  task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin, input int stall,
                        input logic check_lat, input string tag);
    res_t r;
    int   lat;
    r = model(a, b, sub, cin);
    issue(d, a, b, sub, cin);
    wait_out(d, lat);
    if (check_lat) chk($sformatf("%s latency dut%0d", tag, d), 64'(lat), 64'(exp_lat(d)));
    else if (!out_valid[d]) chk($sformatf("%s out_valid dut%0d", tag, d), 64'd0, 64'd1);
    for (int i = 0; i < stall; i++) tick();
    chk($sformatf("%s s dut%0d", tag, d), s_o[d], r.s);
    chk($sformatf("%s flags dut%0d", tag, d), 64'(f_o[d]), 64'(r.f));
    drain(d);
  endtask

  function automatic logic [63:0] pick();
    unique case ($urandom_range(0, 11))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'(32'($urandom_range(0, 3)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    vec_t        vecs [8];
    res_t        r;
    int          lat;
    logic [63:0] held_s;
    logic [3:0]  held_f;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 4'b0000};
    vecs[1] = '{64'd5, 64'd5, 1'b1, 1'b1, 64'd0, 4'b0110};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[3] = '{64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 4'b0110};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 4'b0111};
    vecs[6] = '{64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[7] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 4'b0000};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; sub_i[d] = 1'b0; cin_i[d] = 1'b0;
      a_i[d] = '0; b_i[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset in_ready dut%0d", d), 64'(in_ready[d]), 64'd0);
      chk($sformatf("reset out_valid dut%0d", d), 64'(out_valid[d]), 64'd0);
      chk($sformatf("reset s dut%0d", d), s_o[d], 64'd0);
      chk($sformatf("reset flags dut%0d", d), 64'(f_o[d]), 64'd0);
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("post-reset in_ready dut%0d", d), 64'(in_ready[d]), 64'd1);

    // Directed table, both builds.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        issue(d, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
        wait_out(d, lat);
        chk($sformatf("vec%0d latency dut%0d", i, d), 64'(lat), 64'(exp_lat(d)));
        chk($sformatf("vec%0d s dut%0d", i, d), s_o[d], vecs[i].exp_s);
        chk($sformatf("vec%0d flags dut%0d", i, d), 64'(f_o[d]), 64'(vecs[i].exp_f));
        drain(d);
      end
    end

    // Back-pressure in DONE with competing in_valid.
    r = model(64'h1234, 64'h1111, 1'b0, 1'b0);
    issue(0, 64'h1234, 64'h1111, 1'b0, 1'b0);
    wait_out(0, lat);
    held_s = s_o[0];
    held_f = f_o[0];
    chk("stall initial s", held_s, r.s);
    a_i[0] = 64'hDEAD_BEEF_0000_0001; b_i[0] = 64'h1; in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d out_valid", i), 64'(out_valid[0]), 64'd1);
      chk($sformatf("stall%0d s", i), s_o[0], held_s);
      chk($sformatf("stall%0d flags", i), 64'(f_o[0]), 64'(held_f));
      chk($sformatf("stall%0d in_ready", i), 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b0;
    drain(0);
    chk("stall release in_ready", 64'(in_ready[0]), 64'd1);
    run_op(0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 0, 1'b1, "after_stall");

    // Reset asserted mid-RUN.
    issue(0, 64'h1234, 64'd1, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrun reset out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrun reset s", s_o[0], 64'd0);
    chk("midrun reset flags", 64'(f_o[0]), 64'd0);
    chk("midrun reset in_ready", 64'(in_ready[0]), 64'd0);
    reset = 1'b0;
    tick();
    chk("midrun release in_ready", 64'(in_ready[0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midrun idle%0d out_valid", i), 64'(out_valid[0]), 64'd0);
    end
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1, "after_reset");
    run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1, "after_reset");

    // Random scoreboard, both builds.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(d, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
